regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ writeback requesters
//  (e.g. ALU writeback, load writeback). Each requester uses valid/ready.
//  The arbiter picks one winner per cycle by round-robin and registers the winner's

---
 rtl/regfile_write_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters.
// Optional stats counter enabled by defining REGWR_ARB_STATS_EN.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
`ifdef REGWR_ARB_STATS_EN
   output logic [15:0]                 conflict_cnt,
`endif
   output logic [ADDR_W-1:0]           wr_reg,
   output logic                        reg_write,
   output logic [DATA_W-1:0]           wr_data,
   output logic [$clog2(NUM_REQ)-1:0]  rr_ptr
);

   localparam int          PTR_W = $clog2(NUM_REQ);
   localparam int unsigned NR    = NUM_REQ;

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]  wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic               reg_write_q, reg_write_d;

   logic [NUM_REQ-1:0] grant;
   logic               found;
   logic [PTR_W-1:0]   gidx;
   logic [PTR_W-1:0]   cand;
   logic [ADDR_W-1:0]  addr_sel;
   logic [DATA_W-1:0]  data_sel;

   // Search from rr_ptr upward with wrap; first valid requester wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      gidx  = '0;
      cand  = '0;
      if (!reset && !stall) begin
         for (int unsigned i = 0; i < NR; i++) begin
            cand = PTR_W'((32'(rr_ptr_q) + i) % NR);
            if (!found && req_valid[cand]) begin
               found       = 1'b1;
               grant[cand] = 1'b1;
               gidx        = cand;
            end
         end
      end
   end

   always_comb begin
      addr_sel = '0;
      data_sel = '0;
      for (int unsigned j = 0; j < NR; j++) begin
         if (32'(gidx) == j) begin
            addr_sel = req_addr[j*ADDR_W +: ADDR_W];
            data_sel = req_data[j*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      wr_reg_d    = wr_reg_q;
      wr_data_d   = wr_data_q;
      reg_write_d = 1'b0;
      if (found) begin
         rr_ptr_d    = (gidx == PTR_W'(NR - 1)) ? '0 : gidx + 1'b1;
         wr_reg_d    = addr_sel;
         wr_data_d   = data_sel;
         // The all-ones address is the zero register: acked but never written.
         reg_write_d = (addr_sel != '1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
         reg_write_q <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         wr_reg_q    <= wr_reg_d;
         wr_data_q   <= wr_data_d;
         reg_write_q <= reg_write_d;
      end
   end

`ifdef REGWR_ARB_STATS_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (!stall && ($countones(req_valid) >= 2) && (conflict_cnt_q != '1))
         conflict_cnt_d = conflict_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) conflict_cnt_q <= '0;
      else       conflict_cnt_q <= conflict_cnt_d;
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

   assign req_ready = grant;
   assign wr_reg    = wr_reg_q;
   assign wr_data   = wr_data_q;
   assign reg_write = reg_write_q;
   assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (NUM_REQ=2, ADDR_W=5, DATA_W=64).
module tb_regfile_write_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall;
   logic [1:0]    req_valid;
   logic [9:0]    req_addr;
   logic [127:0]  req_data;
   logic [1:0]    req_ready;
   logic [4:0]    wr_reg;
   logic          reg_write;
   logic [63:0]   wr_data;
   logic [0:0]    rr_ptr;
`ifdef REGWR_ARB_STATS_EN
   logic [15:0]   conflict_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
`ifdef REGWR_ARB_STATS_EN
      .conflict_cnt (conflict_cnt),
`endif
      .wr_reg    (wr_reg),
      .reg_write (reg_write),
      .wr_data   (wr_data),
      .rr_ptr    (rr_ptr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                          input logic [4:0] a1, input logic [63:0] d1);
      req_valid = v;
      req_addr  = {a1, a0};
      req_data  = {d1, d0};
      #1;
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      set_req(2'b11, 5'd0, 64'h0, 5'd0, 64'h0);

      // Reset held two cycles with both requesters valid
      tick();
      tick();
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_rw",    64'(reg_write), 64'h0);
      check("rst_ptr",   64'(rr_ptr),    64'h0);
      check("rst_wreg",  64'(wr_reg),    64'h0);
      check("rst_wdata", wr_data,        64'h0);
      reset = 1'b0;
      #1;
      check("rel_ready", 64'(req_ready), 64'h1);
      set_req(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      tick();

      // Single requester 1
      set_req(2'b10, 5'd0, 64'h0, 5'd7, 64'hA5);
      check("r1_ready", 64'(req_ready), 64'h2);
      tick();
      set_req(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      check("r1_wreg",  64'(wr_reg),    64'd7);
      check("r1_wdata", wr_data,        64'hA5);
      check("r1_rw",    64'(reg_write), 64'h1);
      check("r1_ptr",   64'(rr_ptr),    64'h0);
      tick();
      check("idle_rw",   64'(reg_write), 64'h0);
      check("idle_wreg", 64'(wr_reg),    64'd7);

      // Both valid: alternating grants 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         set_req(2'b11, 5'd3, 64'h100 + 64'(i), 5'd4, 64'h200 + 64'(i));
         check("rr_ready", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
         tick();
         check("rr_rw",    64'(reg_write), 64'h1);
         check("rr_wreg",  64'(wr_reg),    (i % 2 == 0) ? 64'd3 : 64'd4);
         check("rr_wdata", wr_data,        (i % 2 == 0) ? 64'h100 + 64'(i) : 64'h200 + 64'(i));
      end
      check("rr_ptr_end", 64'(rr_ptr), 64'h0);

      // Write to register 31: acked, advances pointer, no write enable
      set_req(2'b01, 5'd31, 64'hDEAD, 5'd0, 64'h0);
      check("xzr_ready", 64'(req_ready), 64'h1);
      tick();
      set_req(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      check("xzr_rw",    64'(reg_write), 64'h0);
      check("xzr_wreg",  64'(wr_reg),    64'd31);
      check("xzr_wdata", wr_data,        64'hDEAD);
      check("xzr_ptr",   64'(rr_ptr),    64'h1);

      // Stall for three cycles with both valid
      stall = 1'b1;
      set_req(2'b11, 5'd5, 64'h55, 5'd9, 64'h99);
      for (int i = 0; i < 3; i++) begin
         check("stl_ready", 64'(req_ready), 64'h0);
         tick();
         check("stl_rw",   64'(reg_write), 64'h0);
         check("stl_ptr",  64'(rr_ptr),    64'h1);
         check("stl_wreg", 64'(wr_reg),    64'd31);
      end
      stall = 1'b0;
      #1;
      check("unstl_ready", 64'(req_ready), 64'h2);
      tick();
      check("unstl_wreg",  64'(wr_reg),    64'd9);
      check("unstl_wdata", wr_data,        64'h99);
      check("unstl_rw",    64'(reg_write), 64'h1);
      check("unstl_ptr",   64'(rr_ptr),    64'h0);

      // Reset asserted with requests pending drops the grant
      set_req(2'b11, 5'd6, 64'h66, 5'd8, 64'h88);
      reset = 1'b1;
      #1;
      check("mrst_ready", 64'(req_ready), 64'h0);
      tick();
      check("mrst_rw",   64'(reg_write), 64'h0);
      check("mrst_wreg", 64'(wr_reg),    64'h0);
      check("mrst_ptr",  64'(rr_ptr),    64'h0);

`ifdef REGWR_ARB_STATS_EN
      check("cnt_rst", 64'(conflict_cnt), 64'h0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("cnt_10", 64'(conflict_cnt), 64'd10);
      for (int i = 0; i < 65525; i++) tick();
      check("cnt_max", 64'(conflict_cnt), 64'hFFFF);
      for (int i = 0; i < 5; i++) tick();
      check("cnt_sat", 64'(conflict_cnt), 64'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
